// File: rtl/mdu_hilo_pkg.sv
// Shared MDUOP encodings for the multiply/divide unit and the controller that drives it.
package mdu_hilo_pkg;

   typedef enum logic [2:0] {
      MDU_NONE  = 3'b000,
      MDU_MULT  = 3'b001,
      MDU_MULTU = 3'b010,
      MDU_DIV   = 3'b011,
      MDU_DIVU  = 3'b100,
      MDU_MTHI  = 3'b101,
      MDU_MTLO  = 3'b110,
      MDU_RSVD  = 3'b111
   } mdu_op_e;

   function automatic logic is_div_op(input mdu_op_e op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

endpackage

// File: rtl/mdu_hilo_if.sv
// Execute-stage bundle between the operand/control side and the MDU.
interface mdu_hilo_if;

   logic [31:0] A;
   logic [31:0] B;
   logic [2:0]  MDUOP;
   logic        start;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (output A, B, MDUOP, start, input busy, HI, LO);
   modport slave  (input A, B, MDUOP, start, output busy, HI, LO);

endinterface

// File: rtl/mdu_arith.sv
// Combinational 64-bit {hi,lo} result for mult/multu/div/divu, plus a divide-by-zero flag.
module mdu_arith
   import mdu_hilo_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  mdu_op_e     op_i,
   output logic [63:0] result_o,
   output logic        div_zero_o
);

   logic [63:0] prod_s, prod_u;
   logic [31:0] a_mag, b_mag, b_mag_safe, b_safe;
   logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;

   // Signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000 cleanly.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      result_o   = 64'd0;
      div_zero_o = is_div_op(op_i) && (b_i == 32'd0);

      prod_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
      prod_u = {32'd0, a_i} * {32'd0, b_i};

      a_mag      = a_i[31] ? (32'd0 - a_i) : a_i;
      b_mag      = b_i[31] ? (32'd0 - b_i) : b_i;
      b_mag_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
      b_safe     = (b_i == 32'd0) ? 32'd1 : b_i;

      q_mag = a_mag / b_mag_safe;
      r_mag = a_mag % b_mag_safe;
      q_s   = (a_i[31] ^ b_i[31]) ? (32'd0 - q_mag) : q_mag;
      r_s   = a_i[31] ? (32'd0 - r_mag) : r_mag;
      q_u   = a_i / b_safe;
      r_u   = a_i % b_safe;

      case (op_i)
         MDU_MULT:  result_o = prod_s;
         MDU_MULTU: result_o = prod_u;
         MDU_DIV:   result_o = {r_s, q_s};
         MDU_DIVU:  result_o = {r_u, q_u};
         default:   result_o = 64'd0;
      endcase
   end

endmodule

// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit: result computed at accept, held pending, committed to HI/LO
// after MULT_CYCLES/DIV_CYCLES busy cycles.
module mdu_hilo
   import mdu_hilo_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   mdu_hilo_if.slave   bus
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   mdu_op_e     op;
   logic        accept;
   logic [63:0] arith_res;
   logic        arith_dz;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          busy_q, busy_d;
   logic [31:0]   hi_q, hi_d, lo_q, lo_d;
   logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
   logic          pend_dz_q, pend_dz_d;

   assign op     = mdu_op_e'(bus.MDUOP);
   assign accept = bus.start && !busy_q && (op != MDU_NONE) && (op != MDU_RSVD);

   mdu_arith u_arith (
      .a_i        (bus.A),
      .b_i        (bus.B),
      .op_i       (op),
      .result_o   (arith_res),
      .div_zero_o (arith_dz)
   );

   always_comb begin
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_dz_d = pend_dz_q;

      if (accept) begin
         case (op)
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
               cnt_d     = is_div_op(op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
               pend_hi_d = arith_res[63:32];
               pend_lo_d = arith_res[31:0];
               pend_dz_d = arith_dz;
            end
            MDU_MTHI: hi_d = bus.A;
            MDU_MTLO: lo_d = bus.A;
            default:  ;
         endcase
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
         // Divide-by-zero runs the full window but leaves HI/LO untouched.
         if (cnt_q == CW'(1) && !pend_dz_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
         end
      end

      busy_d = (cnt_d != '0);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         pend_dz_q <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values together.
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         pend_dz_q <= pend_dz_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.HI   = hi_q;
   assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed plus randomized bench for mdu_hilo against an arithmetic reference model.
module tb_mdu_hilo;
   import mdu_hilo_pkg::*;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic clk;
   logic reset_n;
   mdu_hilo_if bus ();

   mdu_hilo #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   logic [31:0] exp_hi, exp_lo;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Reference: what {HI,LO} should become once the op commits.
   function automatic logic [63:0] model(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] hi, input logic [31:0] lo);
      longint sa, sb, sp, sq, sr;
      logic [63:0] ua, ub, up, rq, rr;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      model = {hi, lo};
      case (op)
         MDU_MULT:  begin sp = sa * sb; model = sp; end
         MDU_MULTU: begin up = ua * ub; model = up; end
         MDU_DIV:   if (b != 0) begin
                       sq = sa / sb; sr = sa % sb;
                       rq = sq; rr = sr;
                       model = {rr[31:0], rq[31:0]};
                    end
         MDU_DIVU:  if (b != 0) begin
                       rq = ua / ub; rr = ua % ub;
                       model = {rr[31:0], rq[31:0]};
                    end
         MDU_MTHI:  model = {a, lo};
         MDU_MTLO:  model = {hi, a};
         default:   ;
      endcase
   endfunction

   // Issue one op; optionally drive a second start on busy-window cycle inj_at (must be ignored).
   task automatic run_op(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input int inj_at, input mdu_op_e inj_op,
                         input logic [31:0] inj_a, input logic [31:0] inj_b);
      logic [63:0] res;
      int n;
      res = model(op, a, b, exp_hi, exp_lo);
      n = (op == MDU_MULT || op == MDU_MULTU) ? MULT_N :
          (op == MDU_DIV  || op == MDU_DIVU)  ? DIV_N  : 0;
      @(negedge clk);
      bus.MDUOP = op; bus.A = a; bus.B = b; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0; bus.MDUOP = MDU_NONE;
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s busy[%0d]", op.name(), i), {63'd0, bus.busy}, 64'd1);
         check($sformatf("%s hold[%0d]", op.name(), i), {bus.HI, bus.LO}, {exp_hi, exp_lo});
         if (i == inj_at) begin
            bus.MDUOP = inj_op; bus.A = inj_a; bus.B = inj_b; bus.start = 1'b1;
         end else begin
            bus.start = 1'b0; bus.MDUOP = MDU_NONE;
         end
         @(negedge clk);
      end
      bus.start = 1'b0; bus.MDUOP = MDU_NONE;
      exp_hi = res[63:32];
      exp_lo = res[31:0];
      check($sformatf("%s busy_done", op.name()), {63'd0, bus.busy}, 64'd0);
      check($sformatf("%s hilo a=%h b=%h", op.name(), a, b), {bus.HI, bus.LO}, {exp_hi, exp_lo});
   endtask

   initial begin
      mdu_op_e rop, iop;
      logic [31:0] ra, rb;
      bus.A = '0; bus.B = '0; bus.MDUOP = MDU_NONE; bus.start = 1'b0;
      exp_hi = '0; exp_lo = '0;

      reset_n = 1'b0;
      #1;
      check("reset busy", {63'd0, bus.busy}, 64'd0);
      check("reset hilo", {bus.HI, bus.LO}, 64'd0);
      @(negedge clk);
      reset_n = 1'b1;

      run_op(MDU_MULT,  32'hFFFF_FFFF, 32'd2, -1, MDU_NONE, 0, 0);
      check("mult plan", {bus.HI, bus.LO}, 64'hFFFF_FFFF_FFFF_FFFE);
      run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, -1, MDU_NONE, 0, 0);
      check("multu plan", {bus.HI, bus.LO}, 64'h0000_0001_FFFF_FFFE);
      run_op(MDU_DIV,   32'hFFFF_FFF9, 32'd2, -1, MDU_NONE, 0, 0);
      check("div plan", {bus.HI, bus.LO}, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op(MDU_DIVU,  32'd7, 32'd2, -1, MDU_NONE, 0, 0);
      check("divu plan", {bus.HI, bus.LO}, {32'd1, 32'd3});

      run_op(MDU_MTHI, 32'h11, 32'd0, -1, MDU_NONE, 0, 0);
      run_op(MDU_MTLO, 32'h22, 32'd0, -1, MDU_NONE, 0, 0);
      run_op(MDU_DIV,  32'd5,  32'd0, -1, MDU_NONE, 0, 0);
      check("div0 plan", {bus.HI, bus.LO}, {32'h11, 32'h22});
      run_op(MDU_DIVU, 32'd9,  32'd0, -1, MDU_NONE, 0, 0);
      run_op(MDU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, -1, MDU_NONE, 0, 0);
      check("div ovf plan", {bus.HI, bus.LO}, {32'd0, 32'h8000_0000});

      run_op(MDU_MULTU, 32'd3, 32'd4, 1, MDU_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("ignored mult plan", {bus.HI, bus.LO}, {32'd0, 32'd12});
      run_op(MDU_MTLO, 32'hDEAD_BEEF, 32'd0, -1, MDU_NONE, 0, 0);
      run_op(MDU_MULTU, 32'd3, 32'd4, 2, MDU_MTHI, 32'hCAFE_F00D, 32'd0);
      check("ignored mthi plan", {bus.HI, bus.LO}, {32'd0, 32'd12});
      run_op(MDU_DIVU, 32'd100, 32'd7, DIV_N - 1, MDU_MULT, 32'd6, 32'd7);
      run_op(MDU_MULT, 32'd6, 32'd7, MULT_N - 1, MDU_MTHI, 32'h5555_5555, 32'd0);
      run_op(MDU_RSVD, 32'h1234_5678, 32'd1, -1, MDU_NONE, 0, 0);
      run_op(MDU_NONE, 32'h1234_5678, 32'd1, -1, MDU_NONE, 0, 0);

      // Asynchronous reset during busy cycle 3 of a div.
      run_op(MDU_MTHI, 32'hA5A5_A5A5, 32'd0, -1, MDU_NONE, 0, 0);
      @(negedge clk);
      bus.MDUOP = MDU_DIV; bus.A = 32'd100; bus.B = 32'd7; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0; bus.MDUOP = MDU_NONE;
      repeat (2) @(negedge clk);
      check("pre-reset busy", {63'd0, bus.busy}, 64'd1);
      #2 reset_n = 1'b0;
      #1;
      check("async reset busy", {63'd0, bus.busy}, 64'd0);
      check("async reset hilo", {bus.HI, bus.LO}, 64'd0);
      exp_hi = '0; exp_lo = '0;
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < DIV_N + 2; i++) begin
         @(negedge clk);
         check($sformatf("post-reset busy[%0d]", i), {63'd0, bus.busy}, 64'd0);
         check($sformatf("post-reset hilo[%0d]", i), {bus.HI, bus.LO}, 64'd0);
      end

      for (int t = 0; t < 30; t++) begin
         rop = mdu_op_e'($urandom_range(1, 6));
         iop = mdu_op_e'($urandom_range(1, 6));
         ra  = $urandom;
         rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) ra = 32'h8000_0000;
         run_op(rop, ra, rb, $urandom_range(0, 12), iop, $urandom, $urandom);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multi-cycle multiply/divide unit with the architectural HI/LO registers.
- Sits in the execute stage beside the ALU. Takes the same forwarded A/B operands.
- Its HI/LO values feed the same execute-stage result mux as the ALU's ANS.
- Raises busy so the hazard unit stalls any mult/div/mf*/mt* instruction that arrives while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, number of busy cycles for mult/multu (must be ≥1).
- DIV_CYCLES, 10, number of busy cycles for div/divu (must be ≥1).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- A  in  32  operand rs (forwarded)
- B  in  32  operand rt (forwarded)
- MDUOP  in  3  operation select:
  - 000 none
  - 001 mult
  - 010 multu
  - 011 div
  - 100 divu
  - 101 mthi
  - 110 mtlo
  - 111 reserved, treated as none
- start  in  1  one-cycle qualifier for MDUOP; ignored when MDUOP=000
- busy  out  1  high while an operation is in flight
- HI  out  32  architectural HI register
- LO  out  32  architectural LO register

Behaviour:
- Reset:
  - reset_n low asynchronously clears HI, LO, busy, the cycle counter and the pending-result registers.
  - Reset is effective immediately, including mid-operation; the in-flight result is discarded.
- Accept rule:
  - An operation is accepted at a rising edge when start=1, busy=0 and MDUOP≠000/111.
  - start while busy=1 is ignored entirely: no state change, and operands are not latched.
- mult/multu/div/divu:
  - At the accept edge, the result is computed from A/B and stored in pending_hi/pending_lo.
  - The counter is loaded with MULT_CYCLES or DIV_CYCLES.
  - busy = (counter≠0), registered, so busy is high from the cycle after the accept edge.
  - The counter decrements each edge. On the edge where counter==1, pending_hi/lo are written to HI/LO and the counter goes to 0.
  - Result: with accept at edge k, busy is high for exactly N cycles. HI/LO change at edge k+N and busy falls at that same edge.
  - HI/LO keep their old values throughout the busy window.
- Arithmetic:
  - mult: signed 32×32→64; HI=[63:32], LO=[31:0].
  - multu: unsigned, same split.
  - div: signed; LO=quotient truncated toward zero; HI=remainder, with the sign of the dividend.
  - div with A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0.
  - divu: unsigned quotient/remainder.
  - Divide by zero (B=0, div or divu): full busy window still runs; HI and LO stay unchanged at commit.
- mthi/mtlo:
  - Accepted only when busy=0.
  - HI (or LO) ← A at the accept edge.
  - busy stays 0; single-cycle operation.
- Reads: HI and LO are plain register outputs; mfhi/mflo are muxed downstream.
- Simultaneous events: reset_n low overrides everything. A start on the commit edge is not accepted, because busy is still 1 on that edge.

Decomposition:
- Shared package/constants file: MDUOP encodings (MDU_NONE, MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO). These are shared with the controller that generates MDUOP.
- One natural sub-module: mdu_arith. It is combinational, computes the 64-bit {hi,lo} for mult/multu/div/divu, and flags divide-by-zero.
- Counter, pending registers and HI/LO live in mdu_hilo.

Test Plan:
- mult A=0xFFFFFFFF, B=2 -> busy high for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (−7), B=2 -> busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=2 -> LO=3, HI=1.
- HI=0x11, LO=0x22, then div A=5, B=0 -> busy for 10 cycles, HI=0x11, LO=0x22 unchanged. div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- multu A=3, B=4, then start with mult A=B=0xFFFFFFFF on busy cycle 2 -> ignored; busy falls after 5 cycles with HI=0, LO=12.
- Idle mtlo A=0xDEADBEEF -> LO=0xDEADBEEF after one edge with busy=0. mthi during a busy window -> HI unaffected, and HI=0 at commit for multu 3×4.
- Reset mid-operation: reset_n low during busy cycle 3 of a div -> busy=0, HI=LO=0 immediately (asynchronous, no clock needed). After release, no delayed commit occurs.
